// File: rtl/sfp_link_supervisor.sv
// sfp_link_supervisor: SFP+ cage manager that debounces status pins and sequences TX_DISABLE, PHY reset and fault retry/lockout
module sfp_link_supervisor #(
  parameter int CLOCK_FREQUENCY    = 125000000,
  parameter int DEBOUNCE_US        = 1000,
  parameter int TX_ENABLE_DELAY_US = 300,
  parameter int FAULT_HOLDOFF_US   = 100000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_sfp_mod0_prsnt_n,
  input  logic       i_sfp_los,
  input  logic       i_sfp_tx_fault,
  output logic       o_sfp_tx_disable,
  output logic       o_phy_reset_n,
  output logic       o_link_up,
  output logic       o_lockout,
  output logic [2:0] o_state,
  output logic [3:0] o_retry_count
);
  localparam int TICKS_PER_US   = CLOCK_FREQUENCY / 1000000;
  localparam int DEBOUNCE_TICKS = TICKS_PER_US * DEBOUNCE_US;
  localparam int ENABLE_TICKS   = TICKS_PER_US * TX_ENABLE_DELAY_US;
  localparam int HOLDOFF_TICKS  = TICKS_PER_US * FAULT_HOLDOFF_US;
  localparam int MAX_DE         = DEBOUNCE_TICKS > ENABLE_TICKS ? DEBOUNCE_TICKS : ENABLE_TICKS;
  localparam int MAX_TICKS      = MAX_DE > HOLDOFF_TICKS ? MAX_DE : HOLDOFF_TICKS;
  localparam int DW             = $clog2(DEBOUNCE_TICKS) + 1;
  localparam int TW             = $clog2(MAX_TICKS) + 1;
  localparam logic [DW-1:0] DB_LAST      = DW'(DEBOUNCE_TICKS - 1);
  localparam logic [TW-1:0] ENABLE_LAST  = TW'(ENABLE_TICKS - 1);
  localparam logic [TW-1:0] HOLDOFF_LAST = TW'(HOLDOFF_TICKS - 1);
  localparam logic [3:0]    MAX_R        = 4'(MAX_RETRIES);
  localparam logic [2:0] PIN_RST     = 3'b011;
  localparam logic [2:0] ABSENT      = 3'd0;
  localparam logic [2:0] INSERT_WAIT = 3'd1;
  localparam logic [2:0] ENABLE      = 3'd2;
  localparam logic [2:0] LINK_UP     = 3'd3;
  localparam logic [2:0] FAULT       = 3'd4;
  localparam logic [2:0] LOCKOUT     = 3'd5;
  logic [2:0] pins, sync1, sync2, filt;
  logic present, los, fault;
  logic [2:0] state, nxt;
  logic [TW-1:0] timer;
  logic [3:0] retry, retry_nxt;
  logic on;
  assign pins = {i_sfp_tx_fault, i_sfp_los, i_sfp_mod0_prsnt_n};
  always_ff @(posedge i_clock) begin
    sync1 <= i_reset ? PIN_RST : pins;
    sync2 <= i_reset ? PIN_RST : sync1;
  end
  for (genvar i = 0; i < 3; i++) begin : g_db
    logic [DW-1:0] cnt;
    logic f;
    always_ff @(posedge i_clock) begin
      if (i_reset) begin
        cnt <= '0;
        f   <= PIN_RST[i];
      end else if (sync2[i] == f) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt <= '0;
        f   <= sync2[i];
      end else begin
        cnt <= cnt + DW'(1);
      end
    end
    assign filt[i] = f;
  end
  assign present = !filt[0];
  assign los     = filt[1];
  assign fault   = filt[2];
  always_comb begin
    nxt = state;
    case (state)
      ABSENT:      nxt = INSERT_WAIT;
      INSERT_WAIT: nxt = fault ? FAULT : timer == ENABLE_LAST ? ENABLE : INSERT_WAIT;
      ENABLE:      nxt = fault ? FAULT : !los ? LINK_UP : ENABLE;
      LINK_UP:     nxt = fault ? FAULT : los ? ENABLE : LINK_UP;
      FAULT:       nxt = timer != HOLDOFF_LAST ? FAULT : retry >= MAX_R ? LOCKOUT : INSERT_WAIT;
      LOCKOUT:     nxt = LOCKOUT;
      default:     nxt = ABSENT;
    endcase
    if (!present) nxt = ABSENT;
  end
  always_comb begin
    on        = nxt == ENABLE || nxt == LINK_UP;
    retry_nxt = nxt == ABSENT ? 4'd0
              : nxt == FAULT && state != FAULT ? (&retry ? retry : retry + 4'd1)
              : state == ENABLE && nxt == LINK_UP ? 4'd0
              : retry;
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state            <= ABSENT;
      timer            <= '0;
      retry            <= '0;
      o_sfp_tx_disable <= 1'b1;
      o_phy_reset_n    <= 1'b0;
      o_link_up        <= 1'b0;
      o_lockout        <= 1'b0;
    end else begin
      state            <= nxt;
      timer            <= nxt != state ? '0 : &timer ? timer : timer + TW'(1);
      retry            <= retry_nxt;
      o_sfp_tx_disable <= !on;
      o_phy_reset_n    <= on;
      o_link_up        <= nxt == LINK_UP;
      o_lockout        <= nxt == LOCKOUT;
    end
  end
  assign o_state       = state;
  assign o_retry_count = retry;
endmodule
